// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED driver.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_e;

    // Counter width for a value range of 0..v-1, never narrower than one bit.
    function automatic int clog2s(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic logic led_select(input led_mode_e m, input logic blink_phase,
                                        input logic pwm_on);
        logic r;
        r = 1'b0;
        case (m)
            LED_OFF:   r = 1'b0;
            LED_ON:    r = 1'b1;
            LED_BLINK: r = blink_phase;
            LED_PWM:   r = pwm_on;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Divides clk into a one-cycle tick every DIV cycles while enabled.
module led_prescaler
    import led_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int W = clog2s(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] presc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (!en) begin
            presc_reg <= '0;
        end else if (presc_reg == LAST) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign tick = en && (presc_reg == LAST);

endmodule

// File: rtl/led_driver.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM with shared blink and PWM timebases.
module led_driver
    import led_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DIV         = 100000,
    parameter int BLINK_TICKS = 500,
    parameter int PWM_BITS    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     on,
    input  logic [2*N_CH-1:0]        mode,
    input  logic [PWM_BITS*N_CH-1:0] duty,
    output logic [N_CH-1:0]          led
);

    localparam int BW = clog2s(BLINK_TICKS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic                tick;
    logic [BW-1:0]       blink_cnt_reg;
    logic                blink_phase_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;

    led_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (on),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (!on) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (tick) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
        end else if (!on) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        led_mode_e           ch_mode;
        logic [PWM_BITS-1:0] ch_duty;
        logic                pwm_on;
        logic                led_next;
        logic                led_reg;

        assign ch_mode = led_mode_e'(mode[2*gi +: 2]);
        assign ch_duty = duty[PWM_BITS*gi +: PWM_BITS];
        // All-ones duty means fully on, not (2**PWM_BITS-1)/2**PWM_BITS.
        assign pwm_on  = (ch_duty == '1) || (pwm_cnt_reg < ch_duty);

        always_comb begin
            led_next = 1'b0;
            if (on) begin
                led_next = led_select(ch_mode, blink_phase_reg, pwm_on);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                led_reg <= 1'b0;
            end else begin
                led_reg <= led_next;
            end
        end

        assign led[gi] = led_reg;
    end

endmodule

// File: tb/tb_led_driver.sv
// Randomised and directed checks of led_driver against a cycle-count based reference model.
module tb_led_driver;

    localparam int NCH = 4;
    localparam int DIV = 4;
    localparam int BT  = 3;
    localparam int PB  = 3;

    logic              clk;
    logic              rst;
    logic              on;
    logic [2*NCH-1:0]  mode;
    logic [PB*NCH-1:0] duty;
    logic [NCH-1:0]    led;

    int total = 0;
    int bad   = 0;

    led_driver #(.N_CH(NCH), .DIV(DIV), .BLINK_TICKS(BT), .PWM_BITS(PB)) dut (
        .clk  (clk),
        .rst  (rst),
        .on   (on),
        .mode (mode),
        .duty (duty),
        .led  (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: k is the number of enabled edges since counters were last cleared.
    function automatic logic ref_bit(input int m, input int d, input int kk);
        int   ph;
        logic pw;
        ph = ((kk / DIV) / BT) % 2;
        pw = (d == (1 << PB) - 1) || ((kk % (1 << PB)) < d);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ph[0];
            default: return pw;
        endcase
    endfunction

    int             k;
    logic [NCH-1:0] exp_led;

    always @(posedge clk or posedge rst) begin
        logic [NCH-1:0] nxt;
        if (rst) begin
            k       = 0;
            exp_led = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                nxt[i] = on ? ref_bit(int'(mode[2*i +: 2]), int'(duty[PB*i +: PB]), k) : 1'b0;
            end
            exp_led = nxt;
            k = on ? k + 1 : 0;
        end
    end

    always @(posedge clk) begin
        #1;
        total++;
        if (led !== exp_led) begin
            bad++;
            $display("FAIL model_cmp t=%0t led=%b want=%b", $time, led, exp_led);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end else begin
            $display("check %s ok val=%0h", name, got);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int cnt;

    initial begin
        rst  = 1'b1;
        on   = 1'b1;
        mode = 8'b01_01_01_01;
        duty = '0;

        // 1: reset held with all ON
        cycles(3);
        check("rst_hold", 32'(led), 32'h0);
        rst = 1'b0;
        check("release_instant", 32'(led), 32'h0);
        cycles(2);
        check("all_on_edge2", 32'(led), 32'hF);

        // 2: blink timing from reset release
        rst = 1'b1;
        mode = 8'b00_00_00_10;
        cycles(1);
        rst = 1'b0;
        cycles(12);
        check("blink_low_p12", 32'(led[0]), 32'h0);
        cycles(1);
        check("blink_rise_p13", 32'(led[0]), 32'h1);
        cycles(11);
        check("blink_high_p24", 32'(led[0]), 32'h1);
        cycles(1);
        check("blink_fall_p25", 32'(led[0]), 32'h0);

        // 3: PWM duty on ch1
        mode = 8'b00_00_11_00;
        duty = 12'(3) << 3;
        cycles(1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin cycles(1); cnt += int'(led[1]); end
        check("pwm_duty3", 32'(cnt), 32'd3);
        duty = '0;
        cycles(1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin cycles(1); cnt += int'(led[1]); end
        check("pwm_duty0", 32'(cnt), 32'd0);
        duty = 12'(7) << 3;
        cycles(1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin cycles(1); cnt += int'(led[1]); end
        check("pwm_duty7", 32'(cnt), 32'd8);

        // 4: drop and raise the global enable
        mode = 8'b11_10_01_00;
        duty = 12'(4) << 9;
        cycles(20);
        on = 1'b0;
        cycles(1);
        check("on_drop", 32'(led), 32'h0);
        cycles(4);
        on = 1'b1;
        cycles(1);
        check("on_raise_ch1", 32'(led[1]), 32'h1);
        cycles(11);
        check("raise_blink_p12", 32'(led[2]), 32'h0);
        cycles(1);
        check("raise_blink_p13", 32'(led[2]), 32'h1);

        // 5: mode switch mid-phase
        cycles(14);
        check("sw_low_p27", 32'(led[2]), 32'h0);
        mode = 8'b11_01_01_00;
        cycles(1);
        check("sw_to_on", 32'(led[2]), 32'h1);
        mode = 8'b10_10_01_00;
        cycles(1);
        check("sw_back_phase", 32'(led[2]), 32'h0);
        check("sw_back_align", 32'(led[2]), 32'(led[3]));

        // 6: async reset mid-blink
        cycles(5);
        check("pre_rst_ch1", 32'(led[1]), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_async", 32'(led), 32'h0);
        cycles(1);
        rst = 1'b0;
        cycles(12);
        check("rst_blink_p12", 32'(led[2]), 32'h0);
        cycles(1);
        check("rst_blink_p13", 32'(led[2]), 32'h1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            if ($urandom_range(0, 49) == 0) on = ~on;
            if ($urandom_range(0, 7) == 0) mode = 8'($urandom);
            if ($urandom_range(0, 7) == 0) duty = 12'($urandom);
        end
        rst = 1'b0;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
